// File: rtl/uart_tx_fifo_if.sv
// ============================================================================
// Module      : uart_tx_fifo_if
// Description : Write-side valid/ready handshake for the buffered UART
//               transmitter. The producer uses the master modport and the
//               transmitter uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffered UART transmitter. A circular FIFO with a valid/ready
//               write port feeds a frame FSM that sends start, data (LSB or
//               MSB first), optional parity and one or two stop bits. Frames
//               are sent back-to-back while the FIFO holds data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int    DATA_BITS   = 8,
    parameter int    STOP_BITS   = 1,
    parameter string FIRST_BIT   = "lsb",
    parameter string PARITY_TYPE = "none",
    parameter int    BAUDRATE    = 115200,
    parameter int    CLK_FREQ    = 75_000_000,
    parameter int    FIFO_DEPTH  = 16
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    uart_tx_fifo_if.slave                      wr,
    output logic                               tx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count
);

    localparam int FULLBAUD = CLK_FREQ / BAUDRATE;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = $clog2(FULLBAUD);

    localparam bit MSB_FIRST = (FIRST_BIT == "msb");
    localparam bit PAR_EN    = (PARITY_TYPE != "none");
    localparam bit PAR_ODD   = (PARITY_TYPE == "odd");

    localparam logic [CW-1:0] LAST_CLK  = CW'(FULLBAUD - 1);
    localparam logic [CW-1:0] CLK_ONE   = CW'(1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers (one extra wrap bit distinguishes full
    // from empty when the address bits match)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) &&
                         (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr.tx_ready = !full && !rst;
    assign push        = wr.tx_valid && wr.tx_ready;
    assign head        = mem[rd_ptr[AW-1:0]];

    // Store accepted words; storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr.tx_data;
        end
    end

    // Pointer and occupancy bookkeeping; a reset flushes the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + PTR_ONE;
                2'b01:   fifo_count <= fifo_count - PTR_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        clk_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_next;
    logic [DATA_BITS-1:0] shifted;
    logic                 first_bit;
    logic                 par_bit;
    logic                 par_next;
    logic                 tx_next;
    logic                 busy_next;
    logic                 bit_end;

    assign bit_end = (clk_cnt == LAST_CLK);

    // The bit currently on the line always sits at the outgoing end of
    // the shift register; the register moves one place per data bit.
    if (MSB_FIRST) begin : g_msb_first
        assign shifted   = {shreg[DATA_BITS-2:0], 1'b0};
        assign first_bit = shreg_next[DATA_BITS-1];
    end else begin : g_lsb_first
        assign shifted   = {1'b0, shreg[DATA_BITS-1:1]};
        assign first_bit = shreg_next[0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, pop decision and next line value.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        shreg_next = shreg;
        par_next   = par_bit;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_next = shifted;
                    if (bit_cnt == LAST_DATA) begin
                        state_next = PAR_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end && (bit_cnt == LAST_STOP)) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (pop) begin
            shreg_next = head;
            par_next   = (^head) ^ PAR_ODD;
        end

        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = first_bit;
            PARITY:  tx_next = par_next;
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

    // Bit timing counters, shift register and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            shreg   <= shreg_next;
            par_bit <= par_next;
            tx      <= tx_next;
            busy    <= busy_next;
            if ((state_next != state) || (state == IDLE)) begin
                clk_cnt <= '0;
                bit_cnt <= '0;
            end else if (bit_end) begin
                clk_cnt <= '0;
                bit_cnt <= bit_cnt + 4'd1;
            end else begin
                clk_cnt <= clk_cnt + CLK_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. Four instances cover
//               8N1/lsb (depth 4), 8E2/msb, 8O2/msb and 7O1/lsb framing at
//               16 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_BITS(8)) ifa ();
    uart_tx_fifo_if #(.DATA_BITS(8)) ifb ();
    uart_tx_fifo_if #(.DATA_BITS(8)) ifc ();
    uart_tx_fifo_if #(.DATA_BITS(7)) ifd ();

    logic       a_tx, b_tx, c_tx, d_tx;
    logic       a_busy, b_busy, c_busy, d_busy;
    logic [2:0] a_cnt;
    logic [4:0] b_cnt, c_cnt, d_cnt;

    uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .FIRST_BIT("lsb"), .PARITY_TYPE("none"),
                   .BAUDRATE(1), .CLK_FREQ(16), .FIFO_DEPTH(4))
        dut_a (.clk(clk), .rst(rst), .wr(ifa), .tx(a_tx), .busy(a_busy), .fifo_count(a_cnt));

    uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(2), .FIRST_BIT("msb"), .PARITY_TYPE("even"),
                   .BAUDRATE(1), .CLK_FREQ(16), .FIFO_DEPTH(16))
        dut_b (.clk(clk), .rst(rst), .wr(ifb), .tx(b_tx), .busy(b_busy), .fifo_count(b_cnt));

    uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(2), .FIRST_BIT("msb"), .PARITY_TYPE("odd"),
                   .BAUDRATE(1), .CLK_FREQ(16), .FIFO_DEPTH(16))
        dut_c (.clk(clk), .rst(rst), .wr(ifc), .tx(c_tx), .busy(c_busy), .fifo_count(c_cnt));

    uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(1), .FIRST_BIT("lsb"), .PARITY_TYPE("odd"),
                   .BAUDRATE(1), .CLK_FREQ(16), .FIFO_DEPTH(16))
        dut_d (.clk(clk), .rst(rst), .wr(ifd), .tx(d_tx), .busy(d_busy), .fifo_count(d_cnt));

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic get_tx(input int d);
        case (d)
            0:       return a_tx;
            1:       return b_tx;
            2:       return c_tx;
            default: return d_tx;
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0:       return a_busy;
            1:       return b_busy;
            2:       return c_busy;
            default: return d_busy;
        endcase
    endfunction

    function automatic int get_cnt(input int d);
        case (d)
            0:       return int'(a_cnt);
            1:       return int'(b_cnt);
            2:       return int'(c_cnt);
            default: return int'(d_cnt);
        endcase
    endfunction

    // Called at a negedge; presents one word for exactly one rising edge.
    task automatic push_word(input int d, input logic [8:0] v);
        case (d)
            0:       begin ifa.tx_valid = 1'b1; ifa.tx_data = v[7:0]; end
            1:       begin ifb.tx_valid = 1'b1; ifb.tx_data = v[7:0]; end
            2:       begin ifc.tx_valid = 1'b1; ifc.tx_data = v[7:0]; end
            default: begin ifd.tx_valid = 1'b1; ifd.tx_data = v[6:0]; end
        endcase
        @(negedge clk);
        ifa.tx_valid = 1'b0;
        ifb.tx_valid = 1'b0;
        ifc.tx_valid = 1'b0;
        ifd.tx_valid = 1'b0;
    endtask

    // Line receiver for instance A (8N1): samples mid-bit, records bytes and
    // the cycle each start bit was first seen.
    int         cyc        = 0;
    int         mon_pos    = 0;
    int         stop_err   = 0;
    logic       mon_active = 1'b0;
    logic [7:0] mon_byte   = 8'h00;
    int         rx_q[$];
    int         starts[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!mon_active) begin
            if (a_tx == 1'b0) begin
                mon_active <= 1'b1;
                mon_pos    <= 1;
                starts.push_back(cyc);
            end
        end else if (!a_busy) begin
            mon_active <= 1'b0;
        end else begin
            mon_pos <= mon_pos + 1;
            if ((mon_pos % 16 == 8) && (mon_pos >= 24) && (mon_pos <= 136))
                mon_byte[mon_pos/16-1] <= a_tx;
            if ((mon_pos == 152) && (a_tx !== 1'b1))
                stop_err <= stop_err + 1;
            if (mon_pos == 159) begin
                mon_active <= 1'b0;
                rx_q.push_back(int'(mon_byte));
            end
        end
    end

    typedef struct {
        int         d;
        logic [8:0] data;
        string      bits;   // expected line level per bit period, start bit first
    } vec_t;

    vec_t vecs[5];

    initial begin
        int   bad;
        logic want;
        int   base, sbase, idx, maxc, guard, got, gapbad;
        logic r, saw_full;

        vecs[0] = '{d: 0, data: 9'h055, bits: "0101010101"};
        vecs[1] = '{d: 1, data: 9'h0A3, bits: "010100011011"};
        vecs[2] = '{d: 2, data: 9'h0A3, bits: "010100011111"};
        vecs[3] = '{d: 3, data: 9'h000, bits: "0000000011"};
        vecs[4] = '{d: 0, data: 9'h0A3, bits: "0110001011"};

        ifa.tx_valid = 1'b0; ifa.tx_data = '0;
        ifb.tx_valid = 1'b0; ifb.tx_data = '0;
        ifc.tx_valid = 1'b0; ifc.tx_data = '0;
        ifd.tx_valid = 1'b0; ifd.tx_data = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", int'(a_tx), 1);
        check("rst_busy", int'(a_busy), 0);
        check("rst_count", int'(a_cnt), 0);
        check("rst_ready", int'(ifa.tx_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(ifa.tx_ready), 1);

        // Single frames, every bit checked on each of its 16 cycles
        for (int v = 0; v < 5; v++) begin
            push_word(vecs[v].d, vecs[v].data);
            check($sformatf("v%0d_pre_tx", v), int'(get_tx(vecs[v].d)), 1);
            check($sformatf("v%0d_pre_busy", v), int'(get_busy(vecs[v].d)), 0);
            check($sformatf("v%0d_pre_count", v), get_cnt(vecs[v].d), 1);
            for (int i = 0; i < vecs[v].bits.len(); i++) begin
                want = (vecs[v].bits.getc(i) == 8'h31);
                bad  = 0;
                for (int k = 0; k < 16; k++) begin
                    @(negedge clk);
                    if ((get_tx(vecs[v].d) !== want) || (get_busy(vecs[v].d) !== 1'b1))
                        bad++;
                    if ((i == 0) && (k == 0))
                        check($sformatf("v%0d_count_after_pop", v), get_cnt(vecs[v].d), 0);
                end
                check($sformatf("v%0d_bit%0d_bad_cycles", v, i), bad, 0);
            end
            @(negedge clk);
            check($sformatf("v%0d_idle_tx", v), int'(get_tx(vecs[v].d)), 1);
            check($sformatf("v%0d_idle_busy", v), int'(get_busy(vecs[v].d)), 0);
        end

        // Fill the depth-4 FIFO with 1..6 while the line is busy
        base = rx_q.size(); sbase = starts.size();
        ifa.tx_valid = 1'b1; ifa.tx_data = 8'd1;
        idx = 1; maxc = 0; guard = 0; saw_full = 1'b0;
        while ((idx <= 6) && (guard < 2000)) begin
            r = ifa.tx_ready;
            if ((a_cnt == 3'd4) && !r) saw_full = 1'b1;
            if (int'(a_cnt) > maxc) maxc = int'(a_cnt);
            @(negedge clk);
            guard++;
            if (r) begin
                idx++;
                ifa.tx_data = 8'(idx);
            end
        end
        ifa.tx_valid = 1'b0;
        check("fill_all_accepted", idx, 7);
        check("fill_max_count", maxc, 4);
        check("fill_ready_low_when_full", int'(saw_full), 1);
        repeat (1000) @(negedge clk);
        check("fill_frames_received", rx_q.size() - base, 6);
        for (int j = 0; j < 6; j++) begin
            got = (base + j < rx_q.size()) ? rx_q[base+j] : -1;
            check($sformatf("fill_word%0d", j), got, j + 1);
        end
        gapbad = 0;
        for (int j = 1; j < 6; j++)
            if ((sbase + j >= starts.size()) || (starts[sbase+j] - starts[sbase+j-1] != 160))
                gapbad++;
        check("fill_back_to_back_gaps", gapbad, 0);
        check("fill_idle_busy", int'(a_busy), 0);

        // Push coinciding with the pop at the final stop-bit cycle, count=2
        base = rx_q.size(); sbase = starts.size();
        ifa.tx_valid = 1'b1; ifa.tx_data = 8'h11;
        @(negedge clk); ifa.tx_data = 8'h22;
        @(negedge clk); ifa.tx_data = 8'h33;
        @(negedge clk); ifa.tx_valid = 1'b0;
        check("pp_count_queued", int'(a_cnt), 2);
        repeat (158) @(negedge clk);
        check("pp_last_stop_tx", int'(a_tx), 1);
        check("pp_count_before", int'(a_cnt), 2);
        ifa.tx_valid = 1'b1; ifa.tx_data = 8'h44;
        @(negedge clk);
        ifa.tx_valid = 1'b0;
        check("pp_count_after", int'(a_cnt), 2);
        check("pp_next_start_tx", int'(a_tx), 0);
        check("pp_busy", int'(a_busy), 1);
        repeat (520) @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            got = (base + j < rx_q.size()) ? rx_q[base+j] : -1;
            check($sformatf("pp_word%0d", j), got, (j + 1) * 17);
        end
        gapbad = 0;
        for (int j = 1; j < 4; j++)
            if ((sbase + j >= starts.size()) || (starts[sbase+j] - starts[sbase+j-1] != 160))
                gapbad++;
        check("pp_back_to_back_gaps", gapbad, 0);

        // Reset mid-data-bit with three words queued
        base = rx_q.size();
        ifa.tx_valid = 1'b1; ifa.tx_data = 8'h61;
        @(negedge clk); ifa.tx_data = 8'h62;
        @(negedge clk); ifa.tx_data = 8'h63;
        @(negedge clk); ifa.tx_data = 8'h64;
        @(negedge clk); ifa.tx_valid = 1'b0;
        check("mr_count_queued", int'(a_cnt), 3);
        repeat (30) @(negedge clk);
        check("mr_busy_before", int'(a_busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mr_tx", int'(a_tx), 1);
        check("mr_busy", int'(a_busy), 0);
        check("mr_count", int'(a_cnt), 0);
        check("mr_ready_in_rst", int'(ifa.tx_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("mr_ready_after", int'(ifa.tx_ready), 1);
        bad = 0;
        repeat (400) begin
            @(negedge clk);
            if ((a_tx !== 1'b1) || (a_busy !== 1'b0) || (a_cnt !== 3'd0)) bad++;
        end
        check("mr_quiet_cycles_bad", bad, 0);
        check("mr_no_new_frames", rx_q.size() - base, 0);
        check("stop_bit_errors", stop_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
